uart_tx_scheduler: RTL and testbench



---
 rtl/uart_tx_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin UART transmitter shared by N_REQ word-level requesters.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_scheduler #(
  parameter int word_size    = 8,
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                         internal_clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*word_size-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         bit_from_UART,
  output logic                         busy,
  output logic [$clog2(N_REQ)-1:0]     grant_id
);

  localparam int PW = $clog2(N_REQ);
  localparam int DW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(word_size + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(word_size - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q, div_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [word_size-1:0]   shift_q, shift_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic [PW-1:0]          grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic                   line_q, line_d;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  logic [word_size-1:0]   slice [N_REQ];
  logic [PW-1:0]          grant_idx;
  logic                   grant_found;
  logic                   accept;
  logic                   bit_end;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
      assign slice[gi] = req_data[gi*word_size +: word_size];
    end
  endgenerate

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % N_REQ;
    return sum[PW-1:0];
  endfunction

  // Walk offsets from far to near so the lowest offset from the pointer wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[wrap_idx(ptr_q, i)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(ptr_q, i);
      end
    end
  end

  assign accept  = (state_q == S_IDLE) && grant_found;
  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_START;
          shift_d  = slice[grant_idx];
          grant_d  = grant_idx;
          ptr_d    = wrap_idx(grant_idx, 1);
          busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d = ^slice[grant_idx];
`endif
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
            busy_d    = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Divider restarts on every bit boundary, which includes every state entry.
    div_d = (state_q == S_IDLE || bit_end) ? '0 : div_q + 1'b1;

    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: line_d = parity_d;
`endif
      default:  line_d = 1'b1;
    endcase
  end

  always_ff @(posedge internal_clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      line_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      line_q    <= line_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign bit_from_UART = line_q;
  assign busy          = busy_q;
  assign grant_id      = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected accepts,
// a negedge monitor checks each accept and every cycle of the resulting frame.
module tb_uart_tx_scheduler;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_CYC = (1 + 8 + PAR_BITS + 1) * CPB;
  localparam int GAP       = FRAME_CYC + 1;

  logic        internal_clk = 1'b0;
  logic        rst          = 1'b0;
  logic [3:0]  req_valid    = 4'b0000;
  logic [31:0] req_data     = 32'h07A5_813C;
  logic [3:0]  req_ready;
  logic        bit_from_UART;
  logic        busy;
  logic [1:0]  grant_id;

  uart_tx_scheduler #(
    .word_size(8), .N_REQ(4), .CLKS_PER_BIT(CPB), .STOP_BITS(1)
  ) dut (
    .internal_clk (internal_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .bit_from_UART(bit_from_UART),
    .busy         (busy),
    .grant_id     (grant_id)
  );

  always #5 internal_clk = ~internal_clk;

  typedef struct {
    logic [3:0] ready;
    logic [1:0] gid;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_vec      = 0;
  int   n_fail     = 0;
  int   accept_cnt = 0;
  int   cyc_cnt    = 0;
  int   last_acc   = 0;
  int   frame_cyc  = 0;
  bit   in_frame   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int fc);
    int b;
    b = fc / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  task automatic push_exp(input logic [3:0] r, input logic [1:0] g, input logic [7:0] d, input int gap);
    exp_t e;
    e.ready = r;
    e.gid   = g;
    e.data  = d;
    e.gap   = gap;
    exp_q.push_back(e);
  endtask

  // Returns just after the handshake edge of the n-th accept.
  task automatic wait_accepts(input int n);
    int t;
    t = 0;
    while (accept_cnt < n && t < 400) begin
      @(negedge internal_clk);
      #1;
      t++;
    end
    if (accept_cnt < n) check("accept_timeout", accept_cnt, n);
    @(posedge internal_clk);
    #1;
  endtask

  always @(negedge internal_clk) begin
    cyc_cnt++;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (in_frame) begin
        if (frame_cyc < FRAME_CYC) begin
          check($sformatf("frame_c%0d", frame_cyc), {busy, bit_from_UART},
                {1'b1, exp_bit(cur.data, frame_cyc)});
          if (frame_cyc == 0) check("grant_id", grant_id, cur.gid);
        end else begin
          check("post_frame_idle", {busy, bit_from_UART}, 2'b01);
          in_frame = 1'b0;
        end
        frame_cyc++;
      end
      if (req_ready != 4'b0000) begin
        if (in_frame) begin
          check("ready_while_busy", req_ready, 4'b0000);
        end else if (exp_q.size() == 0) begin
          check("unexpected_accept", req_ready, 4'b0000);
        end else begin
          cur = exp_q.pop_front();
          check("req_ready", req_ready, cur.ready);
          if (cur.gap != 0) check("accept_gap", cyc_cnt - last_acc, cur.gap);
          $display("accept: ready=%b data=0x%02h t=%0t", req_ready, cur.data, $time);
          last_acc  = cyc_cnt;
          in_frame  = 1'b1;
          frame_cyc = 0;
          accept_cnt++;
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("rst_line",  bit_from_UART, 1'b1);
    check("rst_busy",  busy, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    check("rst_grant", grant_id, 2'd0);
    repeat (2) @(posedge internal_clk);
    #1 rst = 1'b0;

    // All four valid for five frames: 0,1,2,3,0.
    push_exp(4'b0001, 2'd0, 8'h3C, 0);
    push_exp(4'b0010, 2'd1, 8'h81, GAP);
    push_exp(4'b0100, 2'd2, 8'hA5, GAP);
    push_exp(4'b1000, 2'd3, 8'h07, GAP);
    push_exp(4'b0001, 2'd0, 8'h3C, GAP);
    req_valid = 4'b1111;
    wait_accepts(5);
    req_valid = 4'b0000;

    // Grant 3, then 1001 wraps to 0 and back to 3.
    push_exp(4'b1000, 2'd3, 8'h07, 0);
    req_valid = 4'b1000;
    wait_accepts(6);
    push_exp(4'b0001, 2'd0, 8'h3C, GAP);
    push_exp(4'b1000, 2'd3, 8'h07, GAP);
    req_valid = 4'b1001;
    wait_accepts(8);
    req_valid = 4'b0000;

    // Single requester 2 with 0xA5.
    push_exp(4'b0100, 2'd2, 8'hA5, 0);
    req_valid = 4'b0100;
    wait_accepts(9);
    req_valid = 4'b0000;

    // Requester 1 pulses during a busy frame and must be ignored.
    push_exp(4'b0001, 2'd0, 8'h3C, GAP);
    req_valid = 4'b0001;
    wait_accepts(10);
    req_valid = 4'b0000;
    repeat (10) @(posedge internal_clk);
    #1 req_valid = 4'b0010;
    @(posedge internal_clk);
    #1 req_valid = 4'b0000;
    repeat (FRAME_CYC + 20) @(negedge internal_clk);
    #1;
    check("pulse_idle_line", bit_from_UART, 1'b1);
    check("pulse_idle_busy", busy, 1'b0);

    // Reset during the third data bit of a frame from requester 3.
    push_exp(4'b1000, 2'd3, 8'h07, 0);
    req_valid = 4'b1000;
    wait_accepts(11);
    req_valid = 4'b0000;
    repeat (13) @(posedge internal_clk);
    #2 rst = 1'b1;
    #1;
    check("abort_line",  bit_from_UART, 1'b1);
    check("abort_busy",  busy, 1'b0);
    check("abort_ready", req_ready, 4'b0000);
    check("abort_grant", grant_id, 2'd0);
    repeat (2) @(posedge internal_clk);
    #1 rst = 1'b0;
    push_exp(4'b0010, 2'd1, 8'h81, 0);
    req_valid = 4'b0010;
    wait_accepts(12);
    req_valid = 4'b0000;

    repeat (GAP + 10) @(negedge internal_clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("final_line",  bit_from_UART, 1'b1);
    check("final_busy",  busy, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
